mostra_sequencia_controle: RTL and testbench

//  Controller for the sequence-display phase of the memory game. On request from the main control

---
 rtl/mostra_sequencia_controle_pkg.sv | 27 ++
 rtl/mostra_sequencia_controle_if.sv | 23 ++
 rtl/mostra_sequencia_controle_temporizador_led.sv | 26 ++
 rtl/mostra_sequencia_controle.sv | 72 +++++++
 tb/tb_mostra_sequencia_controle.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mostra_sequencia_controle_pkg.sv
// Shared state codes, debug codes and sizing helpers for the sequence-display controller.
package mostra_sequencia_controle_pkg;

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
        ZERA    = 4'h1,
        ACENDE  = 4'h2,
        APAGA   = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'hF
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hE;

    // Timer must hold max(a,b)-1; one spare bit keeps the compare unsigned and safe.
    function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

    function automatic logic [3:0] db_codigo(input estado_t e);
        case (e)
            OCIOSO, ZERA, ACENDE, APAGA, PROXIMO, FIM: return 4'(e);
            default:                                   return DB_INVALIDO;
        endcase
    endfunction

endpackage

// File: rtl/mostra_sequencia_controle_if.sv
// Handshake between the main control unit / datapath and the sequence-display controller.
interface mostra_sequencia_controle_if;
    logic       iniciar;
    logic       abortar;
    logic [3:0] endereco;
    logic [3:0] limite;
    logic       zeraE;
    logic       contaE;
    logic       leds_ativos;
    logic       ocupado;
    logic       fim_mostra;
    logic [3:0] db_estado;

    modport master (
        output iniciar, abortar, endereco, limite,
        input  zeraE, contaE, leds_ativos, ocupado, fim_mostra, db_estado
    );

    modport slave (
        input  iniciar, abortar, endereco, limite,
        output zeraE, contaE, leds_ativos, ocupado, fim_mostra, db_estado
    );
endinterface

// File: rtl/mostra_sequencia_controle_temporizador_led.sv
// Up-counter for LED on/off windows; end flag when the count reaches the selected modulus minus one.
module mostra_sequencia_controle_temporizador_led #(
    parameter int unsigned W = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_zera,
    input  logic         i_conta,
    input  logic [W-1:0] i_m,
    output logic         o_fim_c
);

    logic [W-1:0] r_cnt;

    assign o_fim_c = (r_cnt == (i_m - W'(1)));

    // Wraps to zero on the end count so the next window starts clean.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_zera) begin
            r_cnt <= '0;
        end else if (i_conta) begin
            r_cnt <= o_fim_c ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/mostra_sequencia_controle.sv
// Sequence-display controller: walks address E from 0 to limite, lighting then blanking the LEDs per item.
module mostra_sequencia_controle
    import mostra_sequencia_controle_pkg::*;
#(
    parameter int unsigned TEMPO_ACESO   = 1000,
    parameter int unsigned TEMPO_APAGADO = 500
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    mostra_sequencia_controle_if.slave    bus
);

    localparam int unsigned TW = timer_w(TEMPO_ACESO, TEMPO_APAGADO);

    estado_t       r_estado;
    estado_t       w_prox;
    logic          w_fim_t;
    logic          w_conta_t;
    logic          w_zera_t;
    logic [TW-1:0] w_m;

    function automatic estado_t f_proximo(input estado_t e, input logic ini, input logic abo,
                                          input logic fim_t, input logic ultimo);
        if (abo) return OCIOSO;
        case (e)
            OCIOSO:  return ini ? ZERA : OCIOSO;
            ZERA:    return ACENDE;
            ACENDE:  return fim_t ? APAGA : ACENDE;
            APAGA:   return fim_t ? (ultimo ? FIM : PROXIMO) : APAGA;
            PROXIMO: return ACENDE;
            FIM:     return OCIOSO;
            default: return OCIOSO;
        endcase
    endfunction

    assign w_m       = (r_estado == APAGA) ? TW'(TEMPO_APAGADO) : TW'(TEMPO_ACESO);
    assign w_conta_t = (r_estado == ACENDE) || (r_estado == APAGA);
    assign w_zera_t  = !w_conta_t || bus.abortar;
    assign w_prox    = f_proximo(r_estado, bus.iniciar, bus.abortar, w_fim_t,
                                 bus.endereco == bus.limite);

    mostra_sequencia_controle_temporizador_led #(.W(TW)) u_temporizador (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_zera  (w_zera_t),
        .i_conta (w_conta_t),
        .i_m     (w_m),
        .o_fim_c (w_fim_t)
    );

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado        <= OCIOSO;
            bus.zeraE       <= 1'b0;
            bus.contaE      <= 1'b0;
            bus.leds_ativos <= 1'b0;
            bus.ocupado     <= 1'b0;
            bus.fim_mostra  <= 1'b0;
            bus.db_estado   <= 4'h0;
        end else begin
            r_estado        <= w_prox;
            bus.zeraE       <= (w_prox == ZERA) || (w_prox == FIM);
            bus.contaE      <= (w_prox == PROXIMO);
            bus.leds_ativos <= (w_prox == ACENDE);
            bus.ocupado     <= (w_prox != OCIOSO);
            bus.fim_mostra  <= (w_prox == FIM);
            bus.db_estado   <= db_codigo(w_prox);
        end
    end

endmodule

// File: tb/tb_mostra_sequencia_controle.sv
// Scoreboard bench: expected event timeline per run is queued at start, a monitor pops on every DUT event.
module tb_mostra_sequencia_controle;

    localparam int TA   = 4;
    localparam int TP   = 2;
    localparam int ST   = TA + TP + 1;
    localparam int MAXC = 8192;

    localparam int K_ZERA  = 0;
    localparam int K_ON    = 1;
    localparam int K_OFF   = 2;
    localparam int K_CONTA = 3;
    localparam int K_FIM   = 4;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    logic [3:0] r_e = 4'h0;

    ev_t q[$];
    bit  exp_busy [0:MAXC-1];
    int  tests = 0;
    int  fails = 0;
    int  cur_lim = 0;
    int  cur_c0  = 0;

    mostra_sequencia_controle_if bus ();

    mostra_sequencia_controle #(.TEMPO_ACESO(TA), .TEMPO_APAGADO(TP)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath address counter E
    always @(posedge clk) begin
        if (bus.zeraE)       r_e <= 4'h0;
        else if (bus.contaE) r_e <= r_e + 4'h1;
    end
    assign bus.endereco = r_e;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference timeline: n items, each 1 LED-on window of TA, TP dark, then a contaE cycle.
    task automatic push_run(input int c0, input int lim);
        int n, s, f;
        n = lim + 1;
        f = c0 + n * ST + 1;
        q.push_back('{c0 + 1, K_ZERA});
        for (int k = 0; k < n; k++) begin
            s = c0 + 2 + k * ST;
            q.push_back('{s, K_ON});
            q.push_back('{s + TA, K_OFF});
            if (k < n - 1) q.push_back('{s + TA + TP, K_CONTA});
        end
        q.push_back('{f, K_ZERA});
        q.push_back('{f, K_FIM});
        for (int c = c0 + 1; c <= f; c++) if (c < MAXC) exp_busy[c] = 1'b1;
    endtask

    function automatic bit led_on_at(input int c0, input int lim, input int a);
        for (int k = 0; k <= lim; k++) begin
            if (a >= c0 + 2 + k * ST && a < c0 + 2 + k * ST + TA) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Cancel at cycle a: nothing after a survives except the LEDs dropping.
    task automatic truncate(input int a);
        ev_t keep[$];
        foreach (q[i]) if (q[i].cyc <= a) keep.push_back(q[i]);
        q = keep;
        if (led_on_at(cur_c0, cur_lim, a)) q.push_back('{a + 1, K_OFF});
        for (int c = a + 1; c < a + 200; c++) if (c < MAXC) exp_busy[c] = 1'b0;
    endtask

    task automatic got(input int kind);
        ev_t ev;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL evento_inesperado: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            ev = q.pop_front();
            chk("evento_tipo", kind, ev.kind);
            chk("evento_ciclo", cyc, ev.cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // mode 0: normal (+ ignored iniciar at c0+off), 1: abortar at c0+off, 2: reset at c0+off
    task automatic run(input int lim, input int mode, input int off);
        int c0, f;
        c0 = cyc;
        f  = c0 + (lim + 1) * ST + 1;
        cur_c0  = c0;
        cur_lim = lim;
        bus.limite  = 4'(lim);
        bus.iniciar = 1'b1;
        push_run(c0, lim);
        @(negedge clk);
        bus.iniciar = 1'b0;
        wait_until(c0 + off);
        if (mode == 0) begin
            bus.iniciar = 1'b1;
            @(negedge clk);
            bus.iniciar = 1'b0;
            wait_until(f + 2);
        end else begin
            if (mode == 1) bus.abortar = 1'b1;
            else           rst = 1'b1;
            truncate(c0 + off);
            @(negedge clk);
            bus.abortar = 1'b0;
            rst = 1'b0;
            wait_until(c0 + off + 2);
        end
    endtask

    initial begin : monitor
        logic prev_leds;
        bit   chk_e0;
        prev_leds = 1'b0;
        chk_e0    = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc < MAXC) begin
                chk("ocupado", int'(bus.ocupado), int'(exp_busy[cyc]));
                if (!exp_busy[cyc]) chk("db_ocioso", int'(bus.db_estado), 0);
            end
            if (chk_e0) begin
                chk("E_apos_fim", int'(r_e), 0);
                chk_e0 = 1'b0;
            end
            if (bus.zeraE) got(K_ZERA);
            if (bus.leds_ativos && !prev_leds) got(K_ON);
            if (!bus.leds_ativos && prev_leds) got(K_OFF);
            if (bus.contaE) got(K_CONTA);
            if (bus.fim_mostra) begin
                got(K_FIM);
                chk("db_fim", int'(bus.db_estado), 15);
                chk("E_no_fim", int'(r_e), cur_lim);
                chk_e0 = 1'b1;
            end
            if (bus.leds_ativos) chk("db_acende", int'(bus.db_estado), 2);
            prev_leds = bus.leds_ativos;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lim, mode, off;
        bus.iniciar = 1'b0;
        bus.abortar = 1'b0;
        bus.limite  = 4'h0;

        // Reset held two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_zeraE",   int'(bus.zeraE), 0);
        chk("rst_contaE",  int'(bus.contaE), 0);
        chk("rst_leds",    int'(bus.leds_ativos), 0);
        chk("rst_ocupado", int'(bus.ocupado), 0);
        chk("rst_fim",     int'(bus.fim_mostra), 0);
        chk("rst_db",      int'(bus.db_estado), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single item, three items, then abort at 10 with restart at 15
        run(0, 0, 3);
        repeat (2) @(negedge clk);
        run(2, 0, 12);
        repeat (2) @(negedge clk);
        begin
            int c0;
            c0 = cyc;
            run(2, 1, 10);
            wait_until(c0 + 15);
            run(2, 0, 20);
        end
        repeat (2) @(negedge clk);

        // iniciar held high: back-to-back runs, restart from ocioso at c0+9
        begin
            int c0;
            c0 = cyc;
            cur_c0  = c0;
            cur_lim = 0;
            bus.limite  = 4'h0;
            bus.iniciar = 1'b1;
            push_run(c0, 0);
            push_run(c0 + 9, 0);
            wait_until(c0 + 10);
            bus.iniciar = 1'b0;
            wait_until(c0 + 20);
        end

        // Full 16-item sequence
        run(15, 0, 50);
        repeat (2) @(negedge clk);

        // abortar together with iniciar in ocioso: stays idle
        bus.abortar = 1'b1;
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.abortar = 1'b0;
        bus.iniciar = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized runs: normal with ignored restart, abortar, or reset mid-sequence
        for (int i = 0; i < 14; i++) begin
            lim  = int'($urandom_range(0, 15));
            mode = int'($urandom_range(0, 2));
            off  = int'($urandom_range(1, (lim + 1) * ST));
            run(lim, mode, off);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("fila_vazia", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
